// File: rtl/fast_mult_seq_ctrl.sv
// Sequencer for a shared pipelined 16x16 multiplier cell.
// Builds 32x32 MUL/MULX* results from 3 or 4 partial products.
module fast_mult_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_XSS  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CORR,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc;
  logic [1:0]  iss_cnt;
  logic [1:0]  ret_cnt;

  logic        tag_v [MUL_LAT];
  logic [1:0]  tag_k [MUL_LAT];

  logic        accept;
  logic        issue;
  logic [1:0]  last_k;
  logic        ret_fire;
  logic [1:0]  ret_k;
  logic        ret_last;
  logic [63:0] pp;
  logic        sub_a;
  logic        sub_b;
  logic [31:0] corr_hi;

  assign accept   = req_valid && req_ready;
  assign issue    = (state == S_ISSUE);
  assign last_k   = (op_q == OP_MUL) ? 2'd2 : 2'd3;
  assign ret_fire = tag_v[MUL_LAT-1];
  assign ret_k    = tag_k[MUL_LAT-1];
  assign ret_last = ret_fire && (ret_cnt == last_k);

  // Signed fixups only touch the high word of the unsigned product.
  assign sub_b    = op_q[1] && a_q[31];
  assign sub_a    = (op_q == OP_XSS) && b_q[31];
  assign corr_hi  = acc[63:32]
                  - (sub_b ? b_q : 32'd0)
                  - (sub_a ? a_q : 32'd0);

  always_comb begin
    pp = 64'd0;
    unique case (ret_k)
      2'd0: pp = {32'd0, mul_p};
      2'd1: pp = {16'd0, mul_p, 16'd0};
      2'd2: pp = {16'd0, mul_p, 16'd0};
      2'd3: pp = {mul_p, 32'd0};
      default: pp = 64'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_ISSUE;
      S_ISSUE: if (iss_cnt == last_k) state_nx = S_DRAIN;
      S_DRAIN: if (ret_last) state_nx = S_CORR;
      S_CORR:  state_nx = S_DONE;
      S_DONE:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    mul_en    = 1'b0;
    mul_a     = 16'd0;
    mul_b     = 16'd0;
    unique case (1'b1)
      (state == S_IDLE): begin
        req_ready = !reset;
      end
      issue: begin
        mul_en = 1'b1;
        mul_a  = iss_cnt[0] ? a_q[31:16] : a_q[15:0];
        mul_b  = iss_cnt[1] ? b_q[31:16] : b_q[15:0];
      end
      (state == S_DONE): begin
        rsp_valid = 1'b1;
        rsp_data  = (op_q == OP_MUL) ? acc[31:0] : acc[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (accept) begin
      op_q <= req_op;
      a_q  <= req_src1;
      b_q  <= req_src2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_cnt <= 2'd0;
      ret_cnt <= 2'd0;
    end else if (accept) begin
      iss_cnt <= 2'd0;
      ret_cnt <= 2'd0;
    end else begin
      if (issue) iss_cnt <= iss_cnt + 2'd1;
      if (ret_fire) ret_cnt <= ret_cnt + 2'd1;
    end
  end

  // Tags mirror the cell pipeline so each product meets its shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_k[i] <= 2'd0;
      end
    end else begin
      tag_v[0] <= issue;
      tag_k[0] <= iss_cnt;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_k[i] <= tag_k[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= 64'd0;
    end else if (accept) begin
      acc <= 64'd0;
    end else if (ret_fire) begin
      acc <= acc + pp;
    end else if (state == S_CORR) begin
      acc[63:32] <= corr_hi;
    end
  end

endmodule

// File: tb/tb_fast_mult_seq_ctrl.sv
// Bench for fast_mult_seq_ctrl: MUL_LAT=1 and MUL_LAT=3 instances,
// queued expected results checked at each response handshake.
module tb_fast_mult_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op    [2];
  logic [31:0] req_src1  [2];
  logic [31:0] req_src2  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic [15:0] mul_a     [2];
  logic [15:0] mul_b     [2];
  logic        mul_en    [2];
  logic [31:0] mul_p     [2];

  logic [31:0] p0;
  logic [31:0] p1a;
  logic [31:0] p1b;
  logic [31:0] p1c;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fast_mult_seq_ctrl #(.MUL_LAT(1)) u_lat1 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_src1(req_src1[0]),
    .req_src2(req_src2[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_en(mul_en[0]), .mul_p(mul_p[0])
  );

  fast_mult_seq_ctrl #(.MUL_LAT(3)) u_lat3 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_src1(req_src1[1]),
    .req_src2(req_src2[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_en(mul_en[1]), .mul_p(mul_p[1])
  );

  // External multiplier cells of depth 1 and 3.
  always @(posedge clk) begin
    p0  <= {16'd0, mul_a[0]} * {16'd0, mul_b[0]};
    p1a <= {16'd0, mul_a[1]} * {16'd0, mul_b[1]};
    p1b <= p1a;
    p1c <= p1b;
  end
  assign mul_p[0] = p0;
  assign mul_p[1] = p1c;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'd0, a};
    eb = (op == 2'b11 && b[31]) ? {32'hFFFF_FFFF, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  always @(negedge clk) begin
    if (rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) check("rsp0_extra", q0.size(), 1);
      else check("rsp0_data", rsp_data[0], q0.pop_front());
    end
    if (rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) check("rsp1_extra", q1.size(), 1);
      else check("rsp1_data", rsp_data[1], q1.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then wait for rsp_valid; returns in the cycle
  // after the first rsp_valid cycle.
  task automatic do_op(input int u, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp,
                       input int exp_lat, input int exp_en,
                       output int wait_cnt);
    int cyc;
    int en_cnt;
    bit got_acc;
    bit got_rsp;
    req_valid[u] = 1'b1;
    req_op[u]    = op;
    req_src1[u]  = a;
    req_src2[u]  = b;
    got_acc  = 1'b0;
    wait_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[u]) begin
        got_acc = 1'b1;
        break;
      end
      wait_cnt++;
      tick();
    end
    check("accept_timeout", got_acc, 1);
    if (!got_acc) begin
      req_valid[u] = 1'b0;
      return;
    end
    if (u == 0) q0.push_back(exp);
    else q1.push_back(exp);
    tick();
    req_valid[u] = 1'b0;
    req_op[u]    = 2'($urandom);
    req_src1[u]  = $urandom;
    req_src2[u]  = $urandom;
    cyc     = 1;
    en_cnt  = 0;
    got_rsp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_en[u]) en_cnt++;
      if (rsp_valid[u]) begin
        got_rsp = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    check("rsp_timeout", got_rsp, 1);
    if (exp_lat != 0) check("latency", cyc, exp_lat);
    if (exp_en != 0) check("mul_en_cycles", en_cnt, exp_en);
    tick();
  endtask

  int w;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [1:0]  rop;

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_op[u]    = 2'd0;
      req_src1[u]  = 32'd0;
      req_src2[u]  = 32'd0;
      rsp_ready[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready[0], 0);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_mul_en", mul_en[0], 0);
    check("rst_mul_ab", {mul_a[0], mul_b[0]}, 0);
    check("rst_rsp_data", rsp_data[0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready[0], 1);
    check("idle_req_ready3", req_ready[1], 1);
    tick();

    do_op(0, 2'b00, 32'h0001_0003, 32'h0002_0005,
          32'h000B_000F, 6, 3, w);
    do_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 7, 4, w);
    do_op(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0000_0000, 7, 4, w);
    do_op(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 7, 4, w);
    do_op(0, 2'b11, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 7, 4, w);

    // Response back-pressure with a second request waiting.
    rsp_ready[0] = 1'b0;
    do_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 7, 4, w);
    req_valid[0] = 1'b1;
    req_op[0]    = 2'b00;
    req_src1[0]  = 32'd3;
    req_src2[0]  = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid[0], 1);
      check("hold_rsp_data", rsp_data[0], 32'hFFFF_FFFE);
      check("hold_req_ready", req_ready[0], 0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("hs_req_ready", req_ready[0], 0);
    tick();
    do_op(0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, 0, 3, w);
    check("accept_after_hs", w, 0);

    // Reset during the third issue of MULXUU.
    req_valid[0] = 1'b1;
    req_op[0]    = 2'b01;
    req_src1[0]  = 32'hFFFF_FFFF;
    req_src2[0]  = 32'hFFFF_FFFF;
    @(negedge clk);
    check("pre_rst_ready", req_ready[0], 1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("k2_mul_en", mul_en[0], 1);
    check("k2_mul_ab", {mul_a[0], mul_b[0]}, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    check("arst_mul_en", mul_en[0], 0);
    check("arst_req_ready", req_ready[0], 0);
    tick();
    @(negedge clk);
    check("rst_mid_outs",
          {31'd0, rsp_valid[0], mul_en[0], mul_a[0], mul_b[0]}, 0);
    check("rst_mid_data", rsp_data[0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready[0], 1);
    check("post_rst_valid", rsp_valid[0], 0);
    tick();
    do_op(0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, 6, 3, w);

    do_op(1, 2'b11, 32'hFFFF_FFFE, 32'h0000_0003,
          32'hFFFF_FFFF, 9, 4, w);
    do_op(1, 2'b00, 32'h0001_0003, 32'h0002_0005,
          32'h000B_000F, 8, 3, w);

    for (int n = 0; n < 1500; n++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      do_op(0, rop, ra, rb, ref_mul(rop, ra, rb),
            (rop == 2'b00) ? 6 : 7, 0, w);
    end
    for (int n = 0; n < 1000; n++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      do_op(1, rop, ra, rb, ref_mul(rop, ra, rb),
            (rop == 2'b00) ? 8 : 9, 0, w);
    end

    repeat (3) tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
